// File: rtl/wb_commit_unit.sv
// In-order writeback/commit FIFO: buffers completed instructions from MEM and retires
// one per cycle to the GPR/CSR files, with a commit stream, retire counter and GPR forwarding.
module wb_commit_unit #(
  parameter int XLEN   = 32,
  parameter int GPR_AW = 4,
  parameter int CSR_AW = 12,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_gpr_we,
  input  logic [GPR_AW-1:0] in_gpr_addr,
  input  logic [XLEN-1:0]   in_gpr_data,
  input  logic              in_csr_we,
  input  logic [CSR_AW-1:0] in_csr_addr,
  input  logic [XLEN-1:0]   in_csr_data,
  input  logic              in_irq,
  input  logic [7:0]        in_irq_no,
  input  logic              in_break,
  input  logic [XLEN-1:0]   in_npc,
  output logic              gpr_we,
  output logic [GPR_AW-1:0] gpr_waddr,
  output logic [XLEN-1:0]   gpr_wdata,
  output logic              csr_we,
  output logic [CSR_AW-1:0] csr_waddr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              irq,
  output logic [7:0]        irq_no,
  output logic              commit_valid,
  input  logic              commit_ready,
  output logic [XLEN-1:0]   commit_npc,
  output logic              commit_break,
  output logic              halted,
  output logic [CNT_W-1:0]  retire_cnt,
  input  logic [GPR_AW-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [XLEN-1:0]   fwd_data
);

  // Index width is at least 1 so DEPTH = 1 still has a (constant) slot index.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic              gpr_we;
    logic [GPR_AW-1:0] gpr_addr;
    logic [XLEN-1:0]   gpr_data;
    logic              csr_we;
    logic [CSR_AW-1:0] csr_addr;
    logic [XLEN-1:0]   csr_data;
    logic              irq;
    logic [7:0]        irq_no;
    logic              brk;
    logic [XLEN-1:0]   npc;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic            halted_reg;
  logic [CNT_W-1:0] retire_cnt_reg;

  entry_t          head;
  logic            full;
  logic            empty;
  logic            accept;
  logic            fire;

  function automatic logic [AW-1:0] slot(input logic [PW-1:0] p);
    if (DEPTH == 1) return '0;
    else return AW'(p);
  endfunction

  assign empty  = (wr_ptr_reg == rd_ptr_reg);
  assign full   = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                  (slot(wr_ptr_reg) == slot(rd_ptr_reg));
  assign head   = mem[slot(rd_ptr_reg)];

  assign in_ready     = !full && !halted_reg;
  assign accept       = in_valid && in_ready;
  assign commit_valid = !empty && !halted_reg;
  assign fire         = commit_valid && commit_ready;

  // Strobes are gated by fire; address/data always reflect the head entry.
  assign gpr_we       = fire && head.gpr_we && (head.gpr_addr != '0);
  assign gpr_waddr    = head.gpr_addr;
  assign gpr_wdata    = head.gpr_data;
  assign csr_we       = fire && head.csr_we;
  assign csr_waddr    = head.csr_addr;
  assign csr_wdata    = head.csr_data;
  assign irq          = fire && head.irq;
  assign irq_no       = head.irq_no;
  assign commit_npc   = head.npc;
  assign commit_break = fire && head.brk;
  assign halted       = halted_reg;
  assign retire_cnt   = retire_cnt_reg;

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[slot(wr_ptr_reg)] <= '{
        gpr_we:   in_gpr_we,
        gpr_addr: in_gpr_addr,
        gpr_data: in_gpr_data,
        csr_we:   in_csr_we,
        csr_addr: in_csr_addr,
        csr_data: in_csr_data,
        irq:      in_irq,
        irq_no:   in_irq_no,
        brk:      in_break,
        npc:      in_npc
      };
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      halted_reg     <= 1'b0;
      retire_cnt_reg <= '0;
    end else begin
      if (fire) begin
        if (!head.irq) retire_cnt_reg <= retire_cnt_reg + CNT_W'(1);
        if (head.brk)  halted_reg     <= 1'b1;
      end
      // Flush empties the FIFO by collapsing rd onto the unadvanced wr pointer,
      // which also drops any entry accepted this cycle.
      if (flush) begin
        rd_ptr_reg <= wr_ptr_reg;
      end else begin
        if (fire)   rd_ptr_reg <= rd_ptr_reg + PW'(1);
        if (accept) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
    end
  end

  // Walk from head (oldest) to tail so the last match seen is the youngest.
  always_comb begin
    logic [PW-1:0] count;
    logic [PW-1:0] p;
    entry_t        e;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    count    = wr_ptr_reg - rd_ptr_reg;
    p        = '0;
    e        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      p = rd_ptr_reg + PW'(k);
      e = mem[slot(p)];
      if ((PW'(k) < count) && e.gpr_we && (e.gpr_addr == fwd_addr) && (fwd_addr != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = e.gpr_data;
      end
    end
  end

endmodule

// File: doc/wb_commit_unit.md
Name: wb_commit_unit

Overview:
Parametrised writeback/commit stage that replaces the single-entry pass-through writeback. Buffers up to DEPTH completed instructions from MEM in an in-order FIFO and retires one per cycle to the GPR file and CSR file. Also produces a commit stream (npc, break) for IFU and difftest, keeps a retired-instruction counter, and serves a GPR forwarding lookup over buffered, uncommitted entries.

Parameters:
XLEN, 32, data width of GPR/CSR write data and npc
GPR_AW, 4, GPR address width (RV32E = 4, RV32I = 5)
CSR_AW, 12, CSR address width
DEPTH, 2, commit FIFO entries; power of two, 1..16
CNT_W, 64, retire counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  discard all buffered, uncommitted entries
in_valid  in  1  upstream entry valid
in_ready  out  1  FIFO can accept
in_gpr_we  in  1  entry writes GPR
in_gpr_addr  in  GPR_AW  GPR destination
in_gpr_data  in  XLEN  GPR write data
in_csr_we  in  1  entry writes CSR
in_csr_addr  in  CSR_AW  CSR destination
in_csr_data  in  XLEN  CSR write data
in_irq  in  1  entry is a trap/interrupt
in_irq_no  in  8  trap cause
in_break  in  1  entry is ebreak
in_npc  in  XLEN  next pc of entry
gpr_we  out  1  GPR write strobe
gpr_waddr  out  GPR_AW  GPR write address
gpr_wdata  out  XLEN  GPR write data
csr_we  out  1  CSR write strobe
csr_waddr  out  CSR_AW  CSR write address
csr_wdata  out  XLEN  CSR write data
irq  out  1  trap strobe to CSR file
irq_no  out  8  trap cause
commit_valid  out  1  head entry available to commit
commit_ready  in  1  downstream accepts commit
commit_npc  out  XLEN  npc of committing entry
commit_break  out  1  committing entry is ebreak
halted  out  1  ebreak retired; unit frozen
retire_cnt  out  CNT_W  retired instruction count
fwd_addr  in  GPR_AW  forwarding lookup address
fwd_hit  out  1  buffered entry writes fwd_addr
fwd_data  out  XLEN  data from youngest matching entry

Behaviour:
- Reset: FIFO empty, rd/wr pointers 0, halted 0, retire_cnt 0. Consequently in_ready 1, commit_valid 0, gpr_we/csr_we/irq 0, fwd_hit 0.
- Accept: in_valid && in_ready. in_ready = !full && !halted; it does not depend on commit_ready, so there is no comb path and a full FIFO does not accept in the cycle it drains.
- Latency: an entry accepted at edge N is at head and can commit in cycle N+1 at the earliest. There is no same-cycle bypass.
- commit_valid = !empty && !halted. Commit fire = commit_valid && commit_ready. The head pops at the edge.
- Write strobes are combinational from the head and gated by fire. gpr_we = fire && head.gpr_we && head.gpr_addr != 0. csr_we = fire && head.csr_we. irq = fire && head.irq. Address and data ports always show the head fields.
- retire_cnt increments by 1 on each fire whose head.irq = 0, and wraps modulo 2^CNT_W.
- Break: a fire with head.break sets commit_break = 1 that cycle and sets halted at the edge. While halted: in_ready 0, commit_valid 0, and all strobes 0 until reset.
- Pointers are log2(DEPTH)+1 bits; full/empty are determined by MSB compare. DEPTH = 1 degenerates to a single register slot.
- Flush: at the edge the FIFO empties. A commit firing in the same cycle still completes, including its strobes and counter increment. An entry accepted in the same cycle is dropped.
- Simultaneous accept and fire on a non-full FIFO: occupancy is unchanged and both pointers advance.
- Forwarding (combinational) searches valid entries from youngest to oldest for gpr_we && gpr_addr == fwd_addr && fwd_addr != 0. fwd_hit and fwd_data are taken from the youngest match, and the head is included. No match gives fwd_hit 0 and fwd_data 0.
- Reset asserted mid-operation overrides flush, accept and fire in the same cycle.

Test Plan:
- Reset, then one entry (gpr_we = 1, addr 5, data 0xDEADBEEF, npc 0x80000004) with commit_ready = 1 -> the next cycle gpr_we = 1, waddr 5, wdata 0xDEADBEEF, commit_npc 0x80000004; retire_cnt = 1.
- DEPTH = 2, commit_ready = 0, present 3 entries -> in_ready drops after 2 accepts. Raise commit_ready -> commits come out in order, one per cycle, and retire_cnt = 3.
- Buffer addr 3 = 0x11 (older) and addr 3 = 0x22 (younger), fwd_addr = 3 -> fwd_hit 1, fwd_data 0x22. With fwd_addr = 0 -> fwd_hit 0.
- Entry with gpr_we = 1, addr 0 -> gpr_we stays 0 on commit; retire_cnt still increments.
- Trap entry (irq = 1, irq_no 0x0B, csr_we to 0x341) -> irq and csr_we pulse together with irq_no 0x0B; retire_cnt unchanged.
- FIFO holding 2 entries, flush together with a commit fire -> the head commits, the second entry is never committed, and the FIFO is empty next cycle. A later ebreak commit -> commit_break 1 for that cycle, then halted 1 and in_ready 0 until reset.
